alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit registered ALU. It accepts operation requests (opcode, A, B) from the processor core (requester 0) and a secondary master such as a VGA address or DMA helper (requester 1). It grants one request at a time, drives the ALU input ports and holds them stable through the ALU's one-cycle registered latency. It returns the result to the granted requester over a valid/ready response handshake.

## Interface
Parameters:
- DATA_WIDTH, 8, operand/result width
- OPC_WIDTH, 4, ALU opcode width

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  2  per-requester request valid; bit i = requester i
- REQ_READY  out  2  per-requester accept; at most one bit high
- REQ0_OPCODE / REQ1_OPCODE  in  OPC_WIDTH  requested ALU opcode
- REQ0_A / REQ1_A, REQ0_B / REQ1_B  in  DATA_WIDTH  operands
- RESP_VALID  out  2  result valid for requester i; at most one bit high
- RESP_READY  in  2  requester i consumes result
- RESP_DATA  out  DATA_WIDTH  result, shared by both requesters
- ALU_OPCODE  out  OPC_WIDTH  to ALU opcode input (registered)
- ALU_IN_A, ALU_IN_B  out  DATA_WIDTH  to ALU operand inputs (registered)
- ALU_RESULT  in  DATA_WIDTH  from ALU registered output
- BUSY  out  1  high in any state except IDLE
- GRANT_ID  out  1  index of the current or last granted requester

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - REQ_READY[g] = REQ_VALID[g] for the winning requester g; it is combinational from REQ_VALID and the priority state.
  - On the accept edge: latch REQ{g}_OPCODE/A/B into the ALU_* registers, set GRANT_ID=g, go to EXEC.
- EXEC: ALU_* held stable; the ALU registers the result at the end of this cycle; go to DONE.
- DONE:
  - RESP_VALID[GRANT_ID]=1 and RESP_DATA=ALU_RESULT; ALU_* are still held, so the result stays stable.
  - Stay in DONE until RESP_READY[GRANT_ID]=1, then go to IDLE on that edge.
  - RESP_READY of the non-granted requester is ignored.
- Arbitration with only one REQ_VALID bit set: that requester wins.
- Arbitration with both bits set: see Configuration.
- Handshake rules:
  - A requester holds VALID and its payload stable until READY.
  - Dropping VALID before READY cancels the request with no side effects.
- RESP_DATA is 0 whenever RESP_VALID == 0.
- Outputs have no arithmetic of their own; widths pass through unchanged.
- Reset values: state IDLE, REQ_READY=0, RESP_VALID=0, RESP_DATA=0, ALU_OPCODE=4'hF (ALU default, pass-through A), ALU_IN_A=ALU_IN_B=0, BUSY=0, GRANT_ID=0, priority pointer favours requester 0.
- RESET in any state aborts the in-flight operation: no response is issued and the requester must re-request.

## Timing
- Accept edge ends cycle t. EXEC is cycle t+1. RESP_VALID rises in cycle t+2, so latency is 2 cycles from accept to result.
- Minimum period is 3 cycles per operation, reached when RESP_READY is held high. No request is accepted in EXEC or DONE.
- REQ_READY is never high while BUSY=1.
- The accept in IDLE needs REQ_VALID high in that same cycle. A request arriving during DONE is accepted at the earliest in the first IDLE cycle, i.e. the cycle after the response handshake.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined:
  - On a tie, the requester not granted last wins.
  - The 1-bit pointer updates on every accept.
- ALU_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: requester 0 always wins a tie; requester 1 can starve.
  - The pointer register is not built.

## Structure
- Shared package (or shared header) holds ALU opcode constants (ADD=4'h0 … XNOR=4'hC, PASS_A=4'hF), the FSM state encoding, and DATA_WIDTH/OPC_WIDTH defaults.
- One sub-module: alu_arb_grant.
  - Pure combinational winner selection from REQ_VALID plus the priority pointer.
  - Outputs a one-hot grant and the winner index.
- The FSM and payload registers stay in alu_arbiter. The ALU is instantiated one level up, alongside it.

## Test plan
- Reset then single request:
  - Stimulus: REQ0 ADD, A=8'h12, B=8'h34.
  - Required response: REQ_READY[0] in the same cycle; RESP_VALID[0] 2 cycles later with RESP_DATA=8'h46; BUSY high for 2 cycles, plus stall cycles if RESP_READY is held low.
- Tie, round robin enabled:
  - Stimulus: both requesters hold VALID for 4 operations, REQ0 SUB 8'h10-8'h01 and REQ1 MUL 8'h03*8'h05.
  - Required response: grants alternate 0,1,0,1; results 8'h0F and 8'h0F; no grant overlap.
- Tie, macro undefined:
  - Stimulus: same as the round-robin tie test.
  - Required response: requester 0 is granted all 4 times and REQ_READY[1] stays 0.
- Response backpressure:
  - Stimulus: RESP_READY[0]=0 for 5 cycles.
  - Required response: RESP_VALID[0] and RESP_DATA hold steady, ALU_* unchanged, REQ1 not accepted; REQ1 is accepted in the IDLE cycle after the release.
- Reset mid-operation:
  - Stimulus: RESET asserted during EXEC.
  - Required response: next cycle all outputs at reset values, no RESP_VALID pulse, ALU_OPCODE=4'hF.
- Wrong-requester ready:
  - Stimulus: in DONE for requester 1, assert RESP_READY[0] only.
  - Required response: FSM stays in DONE until RESP_READY[1] is asserted.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter slice: ALU opcodes, default widths and FSM state encoding.
package alu_arbiter_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 8;
  localparam int unsigned ALU_OPC_WIDTH  = 4;

  localparam logic [3:0] ALU_OP_ADD    = 4'h0;
  localparam logic [3:0] ALU_OP_SUB    = 4'h1;
  localparam logic [3:0] ALU_OP_MUL    = 4'h2;
  localparam logic [3:0] ALU_OP_AND    = 4'h3;
  localparam logic [3:0] ALU_OP_OR     = 4'h4;
  localparam logic [3:0] ALU_OP_XOR    = 4'h5;
  localparam logic [3:0] ALU_OP_NOT    = 4'h6;
  localparam logic [3:0] ALU_OP_SHL    = 4'h7;
  localparam logic [3:0] ALU_OP_SHR    = 4'h8;
  localparam logic [3:0] ALU_OP_INC    = 4'h9;
  localparam logic [3:0] ALU_OP_DEC    = 4'hA;
  localparam logic [3:0] ALU_OP_NAND   = 4'hB;
  localparam logic [3:0] ALU_OP_XNOR   = 4'hC;
  localparam logic [3:0] ALU_OP_PASS_A = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational two-way winner selection; on a tie the requester named by prio_i wins.
module alu_arb_grant (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] grant_o,
  output logic       idx_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = 1'b0;
    unique case (valid_i)
      2'b01: begin
        grant_o = 2'b01;
        idx_o   = 1'b0;
      end
      2'b10: begin
        grant_o = 2'b10;
        idx_o   = 1'b1;
      end
      2'b11: begin
        grant_o = prio_i ? 2'b10 : 2'b01;
        idx_o   = prio_i;
      end
      default: begin
        grant_o = '0;
        idx_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester sequencer for the shared registered ALU (IDLE -> EXEC -> DONE).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned OPC_WIDTH  = ALU_OPC_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            REQ_VALID,
  output logic [1:0]            REQ_READY,
  input  logic [OPC_WIDTH-1:0]  REQ0_OPCODE,
  input  logic [OPC_WIDTH-1:0]  REQ1_OPCODE,
  input  logic [DATA_WIDTH-1:0] REQ0_A,
  input  logic [DATA_WIDTH-1:0] REQ1_A,
  input  logic [DATA_WIDTH-1:0] REQ0_B,
  input  logic [DATA_WIDTH-1:0] REQ1_B,
  output logic [1:0]            RESP_VALID,
  input  logic [1:0]            RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic [OPC_WIDTH-1:0]  ALU_OPCODE,
  output logic [DATA_WIDTH-1:0] ALU_IN_A,
  output logic [DATA_WIDTH-1:0] ALU_IN_B,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT,
  output logic                  BUSY,
  output logic                  GRANT_ID
);

  arb_state_e            state_q, state_d;
  logic [OPC_WIDTH-1:0]  opc_q, opc_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  gid_q, gid_d;
  logic [1:0]            win_oh;
  logic                  win_idx;
  logic                  prio;
  logic                  accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Pointer names the requester favoured on the next tie: the one not granted last.
  assign ptr_d = accept ? ~win_idx : ptr_q;
  assign prio  = ptr_q;

  always_ff @(posedge CLK) begin
    if (RESET) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  assign prio = 1'b0;
`endif

  alu_arb_grant u_grant (
    .valid_i (REQ_VALID),
    .prio_i  (prio),
    .grant_o (win_oh),
    .idx_o   (win_idx)
  );

  assign accept = (state_q == ST_IDLE) && (|REQ_VALID);

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    gid_d   = gid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          gid_d   = win_idx;
          opc_d   = win_idx ? REQ1_OPCODE : REQ0_OPCODE;
          a_d     = win_idx ? REQ1_A : REQ0_A;
          b_d     = win_idx ? REQ1_B : REQ0_B;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        if (RESP_READY[gid_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      opc_q   <= OPC_WIDTH'(ALU_OP_PASS_A);
      a_q     <= '0;
      b_q     <= '0;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gid_q   <= gid_d;
    end
  end

  assign REQ_READY  = (state_q == ST_IDLE) ? win_oh : '0;
  assign RESP_VALID = (state_q == ST_DONE) ? (gid_q ? 2'b10 : 2'b01) : '0;
  assign RESP_DATA  = (state_q == ST_DONE) ? ALU_RESULT : '0;
  assign ALU_OPCODE = opc_q;
  assign ALU_IN_A   = a_q;
  assign ALU_IN_B   = b_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign GRANT_ID   = gid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural registered ALU alongside it.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0] req0_opc, req1_opc, alu_opc;
  logic [7:0] req0_a, req1_a, req0_b, req1_b;
  logic [7:0] resp_data, alu_a, alu_b, alu_res;
  logic       busy, grant_id;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_arbiter #(.DATA_WIDTH(8), .OPC_WIDTH(4)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .REQ_VALID   (req_valid),
    .REQ_READY   (req_ready),
    .REQ0_OPCODE (req0_opc),
    .REQ1_OPCODE (req1_opc),
    .REQ0_A      (req0_a),
    .REQ1_A      (req1_a),
    .REQ0_B      (req0_b),
    .REQ1_B      (req1_b),
    .RESP_VALID  (resp_valid),
    .RESP_READY  (resp_ready),
    .RESP_DATA   (resp_data),
    .ALU_OPCODE  (alu_opc),
    .ALU_IN_A    (alu_a),
    .ALU_IN_B    (alu_b),
    .ALU_RESULT  (alu_res),
    .BUSY        (busy),
    .GRANT_ID    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU standing in for the real one instantiated next to the arbiter.
  always_ff @(posedge clk) begin
    case (alu_opc)
      ALU_OP_ADD: alu_res <= alu_a + alu_b;
      ALU_OP_SUB: alu_res <= alu_a - alu_b;
      ALU_OP_MUL: alu_res <= alu_a * alu_b;
      default:    alu_res <= alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".req_ready"},  32'(req_ready),  32'h0);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, ".resp_data"},  32'(resp_data),  32'h0);
    check({tag, ".alu_opc"},    32'(alu_opc),    32'hF);
    check({tag, ".alu_a"},      32'(alu_a),      32'h0);
    check({tag, ".alu_b"},      32'(alu_b),      32'h0);
    check({tag, ".busy"},       32'(busy),       32'h0);
    check({tag, ".grant_id"},   32'(grant_id),   32'h0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [1:0] exp_grant [4];

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0;
    req0_opc = '0; req1_opc = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    // Reset, then a single ADD from requester 0.
    do_reset();
    check_reset_values("rst");
    req_valid = 2'b01; req0_opc = ALU_OP_ADD; req0_a = 8'h12; req0_b = 8'h34;
    #1;
    check("single.ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    check("single.exec_busy",  32'(busy),       32'h1);
    check("single.exec_ready", 32'(req_ready),  32'h0);
    check("single.exec_rv",    32'(resp_valid), 32'h0);
    check("single.alu_a",      32'(alu_a),      32'h12);
    check("single.alu_b",      32'(alu_b),      32'h34);
    step();
    check("single.rv",   32'(resp_valid), 32'h1);
    check("single.data", 32'(resp_data),  32'h46);
    check("single.busy", 32'(busy),       32'h1);
    resp_ready = 2'b01;
    step();
    resp_ready = '0;
    #1;
    check("single.idle_busy", 32'(busy),       32'h0);
    check("single.idle_rv",   32'(resp_valid), 32'h0);
    check("single.idle_data", 32'(resp_data),  32'h0);

    // Tie: both requesters hold VALID for four operations.
    do_reset();
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
    req0_opc = ALU_OP_SUB; req0_a = 8'h10; req0_b = 8'h01;
    req1_opc = ALU_OP_MUL; req1_a = 8'h03; req1_b = 8'h05;
    req_valid = 2'b11; resp_ready = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tie%0d.ready", i), 32'(req_ready), 32'(exp_grant[i]));
      step();
      check($sformatf("tie%0d.exec_ready", i), 32'(req_ready), 32'h0);
      check($sformatf("tie%0d.gid", i), 32'(grant_id), 32'(exp_grant[i][1]));
      step();
      check($sformatf("tie%0d.rv", i), 32'(resp_valid), 32'(exp_grant[i]));
      check($sformatf("tie%0d.data", i), 32'(resp_data), 32'h0F);
      check($sformatf("tie%0d.done_ready", i), 32'(req_ready), 32'h0);
      step();
    end
    req_valid = '0; resp_ready = '0;

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    req0_opc = ALU_OP_ADD; req0_a = 8'h05; req0_b = 8'h07;
    req_valid = 2'b01;
    step();
    req_valid = 2'b10;
    #1;
    check("bp.exec_ready", 32'(req_ready), 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.rv", i),    32'(resp_valid), 32'h1);
      check($sformatf("bp%0d.data", i),  32'(resp_data),  32'h0C);
      check($sformatf("bp%0d.alu_a", i), 32'(alu_a),      32'h05);
      check($sformatf("bp%0d.opc", i),   32'(alu_opc),    32'(ALU_OP_ADD));
      check($sformatf("bp%0d.ready", i), 32'(req_ready),  32'h0);
      step();
    end
    resp_ready = 2'b01;
    step();
    resp_ready = '0;
    #1;
    check("bp.release_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    #1;
    check("bp.r1_gid",   32'(grant_id), 32'h1);
    check("bp.r1_alu_a", 32'(alu_a),    32'h03);
    step();
    check("bp.r1_rv",   32'(resp_valid), 32'h2);
    check("bp.r1_data", 32'(resp_data),  32'h0F);

    // Ready from the non-granted requester must be ignored.
    resp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("wrong%0d.rv", i),   32'(resp_valid), 32'h2);
      check($sformatf("wrong%0d.busy", i), 32'(busy),       32'h1);
    end
    resp_ready = 2'b10;
    step();
    resp_ready = '0;
    #1;
    check("wrong.release_busy", 32'(busy),       32'h0);
    check("wrong.release_rv",   32'(resp_valid), 32'h0);

    // Reset during EXEC aborts the operation.
    do_reset();
    req1_opc = ALU_OP_ADD; req1_a = 8'h21; req1_b = 8'h22;
    req_valid = 2'b10;
    step();
    req_valid = '0;
    #1;
    check("abort.exec_busy", 32'(busy),     32'h1);
    check("abort.exec_gid",  32'(grant_id), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_reset_values("abort");
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("abort%0d.rv", i),   32'(resp_valid), 32'h0);
      check($sformatf("abort%0d.busy", i), 32'(busy),       32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
